// File: rtl/pulse_debounce_array.sv
// Multi-channel debounce filter: per-channel synchroniser, asymmetric acceptance
// thresholds, registered edge strobes and sticky glitch flags.
module pulse_debounce_array #(
    parameter int CH          = 32,
    parameter int CNT_W       = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_20m,
    input  logic             rst_n,
    input  logic [CH-1:0]    pulse_raw,
    input  logic [CNT_W-1:0] rise_coeff,
    input  logic [CNT_W-1:0] fall_coeff,
    input  logic [CH-1:0]    glitch_clr,
    output logic [CH-1:0]    pulse_filtered,
    output logic [CH-1:0]    rise_strb,
    output logic [CH-1:0]    fall_strb,
    output logic [CH-1:0]    glitch_flag
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CH-1:0]    sync_r [SYNC_STAGES];
    logic [CH-1:0]    sync_s;
    logic [CNT_W-1:0] rise_thr_s;
    logic [CNT_W-1:0] fall_thr_s;
    logic [CNT_W-1:0] thr_s      [CH];
    logic [CNT_W:0]   cnt_inc_s  [CH];
    logic [CNT_W-1:0] cnt_r      [CH];
    logic [CNT_W-1:0] cnt_nxt_s  [CH];
    logic [CH-1:0]    filt_r,   filt_nxt_s;
    logic [CH-1:0]    rise_r,   rise_nxt_s;
    logic [CH-1:0]    fall_r,   fall_nxt_s;
    logic [CH-1:0]    glitch_r, glitch_nxt_s;

    assign sync_s     = sync_r[SYNC_STAGES-1];
    // A zero coefficient behaves as a one-clock threshold.
    assign rise_thr_s = (rise_coeff == CNT_ZERO) ? CNT_ONE : rise_coeff;
    assign fall_thr_s = (fall_coeff == CNT_ZERO) ? CNT_ONE : fall_coeff;

    // Per-channel threshold select and widened increment so c+1 never wraps.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign thr_s[g]     = filt_r[g] ? fall_thr_s : rise_thr_s;
        assign cnt_inc_s[g] = {1'b0, cnt_r[g]} + {1'b0, CNT_ONE};
    end

    // Next-state decision per channel: reject, accept, or keep counting.
    always_comb begin
        filt_nxt_s   = filt_r;
        rise_nxt_s   = {CH{1'b0}};
        fall_nxt_s   = {CH{1'b0}};
        glitch_nxt_s = glitch_r & ~glitch_clr;
        for (int i = 0; i < CH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync_s[i] == filt_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
                // Set wins over a coincident clear.
                if (cnt_r[i] != CNT_ZERO) begin
                    glitch_nxt_s[i] = 1'b1;
                end else begin
                    glitch_nxt_s[i] = glitch_r[i] & ~glitch_clr[i];
                end
            end else if (cnt_inc_s[i] >= {1'b0, thr_s[i]}) begin
                filt_nxt_s[i] = sync_s[i];
                cnt_nxt_s[i]  = CNT_ZERO;
                rise_nxt_s[i] = sync_s[i];
                fall_nxt_s[i] = ~sync_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_inc_s[i][CNT_W-1:0];
            end
        end
    end

    // Input synchroniser chain.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {CH{1'b0}};
            end
        end else begin
            sync_r[0] <= pulse_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Filter state, counters and registered outputs.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            filt_r   <= {CH{1'b0}};
            rise_r   <= {CH{1'b0}};
            fall_r   <= {CH{1'b0}};
            glitch_r <= {CH{1'b0}};
            for (int i = 0; i < CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            filt_r   <= filt_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
            glitch_r <= glitch_nxt_s;
            for (int i = 0; i < CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign pulse_filtered = filt_r;
    assign rise_strb      = rise_r;
    assign fall_strb      = fall_r;
    assign glitch_flag    = glitch_r;

endmodule

// File: tb/tb_pulse_debounce_array.sv
// Self-checking bench for pulse_debounce_array: directed scenarios with literal
// expectations plus randomized stimulus against a timestamp-based reference model.
module tb_pulse_debounce_array;

    localparam int CH = 4;
    localparam int CNT_W = 8;
    localparam int SS = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    pulse_raw = 4'h0;
    logic [CNT_W-1:0] rise_coeff = 8'd10;
    logic [CNT_W-1:0] fall_coeff = 8'd5;
    logic [CH-1:0]    glitch_clr = 4'h0;
    logic [CH-1:0]    pulse_filtered, rise_strb, fall_strb, glitch_flag;

    int checks = 0;
    int errors = 0;

    pulse_debounce_array #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .clk_20m(clk), .rst_n(rst_n), .pulse_raw(pulse_raw),
        .rise_coeff(rise_coeff), .fall_coeff(fall_coeff), .glitch_clr(glitch_clr),
        .pulse_filtered(pulse_filtered), .rise_strb(rise_strb),
        .fall_strb(fall_strb), .glitch_flag(glitch_flag)
    );

    always #25 clk = ~clk;

    // Reference model: an excursion is remembered by the cycle it started;
    // it is accepted once it has lasted thr cycles, rejected if it ends sooner.
    int            cyc = 0;
    logic [CH-1:0] raw_hist [8];
    int            start_m [CH];
    logic [CH-1:0] f_m = 4'h0, rs_m = 4'h0, fs_m = 4'h0, gl_m = 4'h0;
    logic          s_m;
    logic          set_m;
    int            thr_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; f_m = 4'h0; rs_m = 4'h0; fs_m = 4'h0; gl_m = 4'h0;
            for (int i = 0; i < CH; i++) start_m[i] = -1;
            for (int k = 0; k < 8; k++) raw_hist[k] = 4'h0;
        end else begin
            cyc = cyc + 1;
            raw_hist[cyc % 8] = pulse_raw;
            rs_m = 4'h0; fs_m = 4'h0;
            for (int i = 0; i < CH; i++) begin
                s_m   = (cyc > SS) ? raw_hist[(cyc - SS) % 8][i] : 1'b0;
                thr_m = f_m[i] ? int'(fall_coeff) : int'(rise_coeff);
                if (thr_m == 0) thr_m = 1;
                set_m = 1'b0;
                if (s_m == f_m[i]) begin
                    set_m = (start_m[i] >= 0);
                    start_m[i] = -1;
                end else begin
                    if (start_m[i] < 0) start_m[i] = cyc;
                    if (cyc - start_m[i] + 1 >= thr_m) begin
                        f_m[i] = s_m;
                        if (s_m) rs_m[i] = 1'b1;
                        else     fs_m[i] = 1'b1;
                        start_m[i] = -1;
                    end
                end
                if (set_m)              gl_m[i] = 1'b1;
                else if (glitch_clr[i]) gl_m[i] = 1'b0;
            end
        end
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check4("model_filtered", pulse_filtered, f_m);
        check4("model_rise",     rise_strb,      rs_m);
        check4("model_fall",     fall_strb,      fs_m);
        check4("model_glitch",   glitch_flag,    gl_m);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pulse_raw = 4'h0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and steady state with all inputs held high.
        pulse_raw = 4'hF;
        tick(3);
        check4("rst_filt", pulse_filtered, 4'h0);
        check4("rst_rise", rise_strb, 4'h0);
        check4("rst_fall", fall_strb, 4'h0);
        check4("rst_glitch", glitch_flag, 4'h0);
        rst_n = 1'b1;
        tick(11);
        check4("s1_edge11", pulse_filtered, 4'h0);
        tick(1);
        check4("s1_edge12_filt", pulse_filtered, 4'hF);
        check4("s1_edge12_rise", rise_strb, 4'hF);
        tick(1);
        check4("s1_edge13_rise", rise_strb, 4'h0);

        // Glitch rejection on ch0.
        do_reset();
        pulse_raw[0] = 1'b1;
        tick(9);
        pulse_raw[0] = 1'b0;
        tick(3);
        check4("s2_glitch", glitch_flag, 4'b0001);
        check4("s2_filt", pulse_filtered, 4'h0);
        tick(5);
        check4("s2_filt_late", pulse_filtered, 4'h0);
        glitch_clr = 4'b0001;
        tick(1);
        glitch_clr = 4'h0;
        check4("s2_clr", glitch_flag, 4'h0);

        // Asymmetric thresholds on ch1.
        pulse_raw[1] = 1'b1;
        tick(12);
        check4("s3_rise_filt", pulse_filtered, 4'b0010);
        check4("s3_rise_strb", rise_strb, 4'b0010);
        pulse_raw[1] = 1'b0;
        tick(4);
        pulse_raw[1] = 1'b1;
        tick(3);
        check4("s3_short_low_glitch", glitch_flag, 4'b0010);
        check4("s3_short_low_filt", pulse_filtered, 4'b0010);
        tick(5);
        pulse_raw[1] = 1'b0;
        tick(6);
        check4("s3_fall_edge6", pulse_filtered, 4'b0010);
        tick(1);
        check4("s3_fall_edge7_filt", pulse_filtered, 4'h0);
        check4("s3_fall_edge7_strb", fall_strb, 4'b0010);

        // Coefficient edge cases on ch2.
        rise_coeff = 8'd0;
        pulse_raw[2] = 1'b1;
        tick(2);
        check4("s4_zero_edge2", pulse_filtered, 4'h0);
        tick(1);
        check4("s4_zero_edge3", pulse_filtered, 4'b0100);
        check4("s4_zero_strb", rise_strb, 4'b0100);
        rise_coeff = 8'd10;
        pulse_raw[2] = 1'b0;
        tick(10);
        pulse_raw[2] = 1'b1;
        tick(8);
        check4("s4_lower_pre", pulse_filtered, 4'h0);
        rise_coeff = 8'd3;
        tick(1);
        check4("s4_lower_filt", pulse_filtered, 4'b0100);
        check4("s4_lower_strb", rise_strb, 4'b0100);
        rise_coeff = 8'd10;

        // Glitch completing on ch3 while its clear is held: set wins.
        glitch_clr = 4'b1000;
        pulse_raw[3] = 1'b1;
        tick(3);
        pulse_raw[3] = 1'b0;
        tick(3);
        check4("s5_set_wins", glitch_flag & 4'b1000, 4'b1000);
        tick(1);
        check4("s5_cleared", glitch_flag & 4'b1000, 4'h0);
        glitch_clr = 4'h0;

        // Ch0..ch2 toggle on the same clock.
        pulse_raw = 4'b0011;
        tick(6);
        check4("s5_tog_edge6", pulse_filtered, 4'b0100);
        tick(1);
        check4("s5_tog_fall", fall_strb, 4'b0100);
        check4("s5_tog_edge7", pulse_filtered, 4'h0);
        tick(5);
        check4("s5_tog_rise", rise_strb, 4'b0011);
        check4("s5_tog_edge12", pulse_filtered, 4'b0011);

        // Reset asserted mid-count on ch2.
        pulse_raw = 4'b0111;
        tick(9);
        rst_n = 1'b0;
        #2;
        check4("s6_rst_filt", pulse_filtered, 4'h0);
        check4("s6_rst_glitch", glitch_flag, 4'h0);
        tick(2);
        rst_n = 1'b1;
        tick(11);
        check4("s6_edge11", pulse_filtered, 4'h0);
        tick(1);
        check4("s6_edge12_filt", pulse_filtered, 4'b0111);
        check4("s6_edge12_rise", rise_strb, 4'b0111);

        // Randomized phase, checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                rise_coeff = 8'($urandom_range(0, 12));
                fall_coeff = 8'($urandom_range(0, 12));
            end
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(0, 9) == 0) pulse_raw[b] = ~pulse_raw[b];
            end
            glitch_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rst_n = (n == 1500) ? 1'b0 : 1'b1;
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
